// File: rtl/fifo_pkg.sv
// Shared defaults, lane-count sizing and the assembly-state encoding for the FIFO read packer.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PACK_RATIO_DEF = 4;

  // Lane counter must hold 0..PACK_RATIO inclusive, hence the extra bit.
  localparam int unsigned LANE_CNT_W = $clog2(PACK_RATIO_DEF) + 1;

  typedef enum logic [1:0] {
    StFill     = 2'd0,
    StComplete = 2'd1,
    StDrain    = 2'd2
  } asm_state_e;

  function automatic int unsigned lane_cnt_width(input int unsigned pack_ratio);
    return $clog2(pack_ratio) + 1;
  endfunction

endpackage

// File: rtl/pack_out_stage.sv
// Output register for the packed word: loads on request and holds data/keep/valid until accepted.
module pack_out_stage
  import fifo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DATA_WIDTH_DEF * PACK_RATIO_DEF,
  parameter int unsigned KEEP_WIDTH = PACK_RATIO_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic [KEEP_WIDTH-1:0] i_keep,
  input  logic                  i_ready,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic [KEEP_WIDTH-1:0] o_keep,
  output logic                  o_valid,
  output logic                  o_free
);

  logic [WORD_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_valid;

  // Register may take a new word when empty or when the current one leaves this cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_valid = r_valid;

  // Load a new word, otherwise drop valid once accepted; hold everything while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Reads DATA_WIDTH entries from a FIFO and packs PACK_RATIO of them little-endian into one word.
// Optional feature: define FIFO_RD_PACKER_FLUSH_EN to add the flush port and partial-word drain.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PACK_RATIO = PACK_RATIO_DEF  // 2, 4 or 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            fifo_data_out,
  input  logic                             fifo_empty,
  output logic                             fifo_read_en,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready
`ifdef FIFO_RD_PACKER_FLUSH_EN
  ,
  input  logic                             flush
`endif
);

  localparam int unsigned WordW    = DATA_WIDTH * PACK_RATIO;
  localparam int unsigned LaneCntW = lane_cnt_width(PACK_RATIO);
  localparam logic [LaneCntW-1:0] PackCnt = LaneCntW'(PACK_RATIO);

  asm_state_e          r_state, w_state_d;
  logic [LaneCntW-1:0] r_lane_cnt, w_lane_cnt_d;
  logic                r_inflight;
  logic [WordW-1:0]    r_lanes, w_lanes_d;

  logic [LaneCntW-1:0] w_lane_cap;   // lanes held once this cycle's in-flight entry lands
  logic [LaneCntW-1:0] w_occupancy;  // lanes committed after any move this cycle
  logic [WordW-1:0]    w_word;       // assembled lanes including the in-flight entry
  logic [PACK_RATIO-1:0] w_keep;
  logic                w_flush_req;
  logic                w_drain;
  logic                w_move;
  logic                w_free;

  // Merge the in-flight entry into its lane so a word can complete and move in one cycle.
  always_comb begin
    w_lane_cap = r_lane_cnt + LaneCntW'(r_inflight);
    w_word     = r_lanes;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      if (r_inflight && (r_lane_cnt == LaneCntW'(i))) begin
        w_word[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data_out;
      end
    end
  end

`ifdef FIFO_RD_PACKER_FLUSH_EN
  // Flush only matters when something is assembled or about to be; keep marks filled lanes.
  always_comb begin
    w_flush_req = flush && ((r_lane_cnt != '0) || r_inflight);
    w_keep      = '0;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      w_keep[i] = (LaneCntW'(i) < w_lane_cap);
    end
  end
`else
  // Without flush every emitted word is full.
  always_comb begin
    w_flush_req = 1'b0;
    w_keep      = '1;
  end
`endif

  // Move decision, read gating and next-state for the assembly FSM.
  always_comb begin
    w_drain      = w_flush_req || (r_state == StDrain);
    w_move       = w_free && ((w_lane_cap == PackCnt) || (w_drain && (w_lane_cap != '0)));
    w_occupancy  = w_lane_cap - (w_move ? PackCnt : '0);
    fifo_read_en = !reset && !fifo_empty && !w_drain && (w_occupancy < PackCnt);

    w_lanes_d    = w_move ? '0 : w_word;
    w_lane_cnt_d = w_move ? '0 : w_lane_cap;

    w_state_d = StFill;
    if (w_move) begin
      w_state_d = StFill;
    end else if (w_drain) begin
      w_state_d = StDrain;
    end else if (w_lane_cap == PackCnt) begin
      w_state_d = StComplete;
    end
  end

  // Assembly state, lane storage and the one-deep read pipeline marker.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StFill;
      r_lane_cnt <= '0;
      r_inflight <= 1'b0;
      r_lanes    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_lane_cnt <= w_lane_cnt_d;
      r_inflight <= fifo_read_en;
      r_lanes    <= w_lanes_d;
    end
  end

  pack_out_stage #(
    .WORD_WIDTH (WordW),
    .KEEP_WIDTH (PACK_RATIO)
  ) u_out_stage (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_move),
    .i_data  (w_word),
    .i_keep  (w_keep),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_keep  (out_keep),
    .o_valid (out_valid),
    .o_free  (w_free)
  );

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of one FIFO entry (one lane).
REQ-002 Parameter PACK_RATIO, default 4, SHALL set the lanes per output word; legal values are 2, 4 and 8.
REQ-003 clock  input  1  SHALL be the single clock; all logic is posedge-clocked.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 fifo_data_out  input  DATA_WIDTH  SHALL carry FIFO read data, valid one cycle after fifo_read_en.
REQ-006 fifo_empty  input  1  SHALL be the FIFO read-side empty flag.
REQ-007 fifo_read_en  output  1  SHALL be the FIFO read strobe.
REQ-008 out_data  output  DATA_WIDTH*PACK_RATIO  SHALL carry the packed word.
REQ-009 out_keep  output  PACK_RATIO  SHALL carry the lane-valid mask, one bit per lane.
REQ-010 out_valid  output  1  SHALL flag that out_data and out_keep are valid.
REQ-011 out_ready  input  1  SHALL be the consumer acceptance; a transfer occurs when out_valid=1 and out_ready=1.
REQ-012 flush  input  1  SHALL request emission of a partial word; the port exists only with FIFO_RD_PACKER_FLUSH_EN.

Function
REQ-013 fifo_read_en SHALL never be 1 in a cycle where fifo_empty=1.
REQ-014 Counters: lane_cnt (0..PACK_RATIO) SHALL count lanes captured; inflight (0/1) SHALL be 1 in the cycle after a read.
REQ-015 A read in cycle N SHALL capture fifo_data_out at the end of cycle N+1 into lane lane_cnt and increment lane_cnt.
REQ-016 Lane packing SHALL be little-endian: the first byte read lands in out_data[DATA_WIDTH-1:0].
REQ-017 Assembly states SHALL be FILL (lane_cnt<PACK_RATIO), COMPLETE (lane_cnt==PACK_RATIO) and, with the macro, DRAIN (flush pending).
REQ-018 The block SHALL move a COMPLETE word to the output register when out_valid=0 or out_ready=1 in the same cycle, and clear lane_cnt.
REQ-019 Read gating: fifo_read_en = !fifo_empty && (lane_cnt - move*PACK_RATIO + inflight) < PACK_RATIO, where move is the REQ-018 transfer in the current cycle.
REQ-020 With fifo_empty=0 and out_ready held 1, throughput SHALL be one lane per cycle with no bubbles.
REQ-021 Latency from the first read to out_valid for a full word SHALL be PACK_RATIO+1 cycles.
REQ-022 out_data, out_keep and out_valid SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-023 out_keep SHALL be all ones for every full word.
REQ-024 A capture, a move and an output transfer in the same cycle SHALL all complete without data loss or duplication.

Reset
REQ-025 During reset, fifo_read_en, out_valid, out_data, out_keep, lane_cnt and inflight SHALL all be 0.
REQ-026 Reset asserted mid-operation SHALL discard partial lanes, the held output word and any in-flight byte; a byte arriving in the cycle after reset SHALL be ignored.
REQ-027 The first fifo_read_en SHALL occur no earlier than the first cycle after reset deasserts.

Configuration
REQ-028 Macro FIFO_RD_PACKER_FLUSH_EN SHALL compile in the flush port and the DRAIN state.
REQ-029 With the macro, flush=1 and (lane_cnt>0 or inflight=1) SHALL enter DRAIN: reads stop, the in-flight byte is captured, and the partial word moves out when the output register is free.
REQ-030 In a DRAIN move, out_keep SHALL have lanes 0..lane_cnt-1 set, unused lanes SHALL be zero, and lane_cnt SHALL clear.
REQ-031 With the macro, flush=1 while lane_cnt=0 and inflight=0 SHALL produce no output.
REQ-032 Without the macro, the port SHALL be absent, out_keep SHALL be constant all ones, and partial lanes SHALL be held indefinitely.

Structure
REQ-033 Package fifo_pkg SHALL hold the DATA_WIDTH and PACK_RATIO defaults, the lane-count width constant ($clog2(PACK_RATIO)+1) and the assembly-state enum.
REQ-034 The output register with its valid/ready hold logic SHALL be a sub-module named pack_out_stage; all remaining logic stays in fifo_rd_packer.

Verification
REQ-035 FIFO holds 0x11,0x22,0x33,0x44; out_ready=1 -> one word out_data=0x44332211, out_keep=4'hF, out_valid high exactly one cycle, 5 cycles after the first read.
REQ-036 Eight bytes 0x01..0x08 with out_ready=1 -> 0x04030201 then 0x08070605 on consecutive words; fifo_read_en high 8 consecutive cycles.
REQ-037 out_ready=0 for 10 cycles with 12 bytes queued -> first word held stable, at most 8 bytes read, no overflow; on release the words arrive in order.
REQ-038 fifo_empty toggles every cycle -> fifo_read_en is never 1 with fifo_empty=1, and the output word order is intact.
REQ-039 Reset for one cycle with lane_cnt=2 and inflight=1 -> no output word, and the next four bytes form a clean word.
REQ-040 With the macro: bytes 0xAA,0xBB then flush=1 -> out_data=0x0000BBAA, out_keep=4'b0011; flush with an empty assembly -> no output.
